// File: rtl/multiplier_pkg.sv
// Shared constants and helpers for the multiplier arbiter slice.
// Provides clog2, the requester-id width rule and the legal requester-count bounds.
package multiplier_pkg;

  localparam int NUM_REQ_MIN = 2;
  localparam int NUM_REQ_MAX = 8;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

  // Never narrower than one bit, so a degenerate count still yields a legal port.
  function automatic int id_w(input int num_req);
    return (num_req < 2) ? 1 : clog2(num_req);
  endfunction

endpackage

// File: rtl/multiplier.sv
// Unsigned full-width combinational multiplier shared by the arbiter datapath.
// The product is never truncated or saturated.
module multiplier #(
  parameter int DATA_WIDTH_1 = 8,
  parameter int DATA_WIDTH_2 = 8,
  localparam int PW = DATA_WIDTH_1 + DATA_WIDTH_2
) (
  input  logic [DATA_WIDTH_1-1:0] a_i,
  input  logic [DATA_WIDTH_2-1:0] b_i,
  output logic [PW-1:0]           p_o
);

  assign p_o = PW'(a_i) * PW'(b_i);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: picks the first asserted request at or after ptr_i, wrapping modulo N.
// Grant is one-hot or zero; en_i low forces zero.
module rr_arbiter
  import multiplier_pkg::*;
#(
  parameter int N = 4,
  localparam int PTR_W = id_w(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  input  logic             en_i,
  output logic [N-1:0]     gnt_o
);

  always_comb begin
    int   idx;
    logic found;
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (en_i && !found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multiplier_arbiter.sv
// Round-robin sharing of one multiplier among NUM_REQ requesters; results return in grant order, tagged by id.
// Define MULTIPLIER_ARB_REG_OUT_EN to register the res_* outputs (latency LAT+1 instead of LAT).
module multiplier_arbiter
  import multiplier_pkg::*;
#(
  parameter int DATA_WIDTH_1 = 8,
  parameter int DATA_WIDTH_2 = 8,
  parameter int NUM_REQ      = 4,
  parameter int LAT          = 2,
  localparam int ID_W        = id_w(NUM_REQ),
  localparam int PW          = DATA_WIDTH_1 + DATA_WIDTH_2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH_1-1:0] req_data1_i,
  input  logic [NUM_REQ*DATA_WIDTH_2-1:0] req_data2_i,
  output logic                            res_valid_o,
  input  logic                            res_ready_i,
  output logic [ID_W-1:0]                 res_id_o,
  output logic [PW-1:0]                   res_data_o
);

  if (NUM_REQ < NUM_REQ_MIN || NUM_REQ > NUM_REQ_MAX) begin : g_bad_num_req
    $error("multiplier_arbiter: NUM_REQ out of range");
  end
  if (LAT < 1) begin : g_bad_lat
    $error("multiplier_arbiter: LAT must be at least 1");
  end

  logic                    stall;
  logic [NUM_REQ-1:0]      gnt;
  logic                    gnt_any;
  logic [ID_W-1:0]         gnt_idx;

  logic [ID_W-1:0]         ptr_q, ptr_d;
  logic [DATA_WIDTH_1-1:0] s0_a_q, s0_a_d;
  logic [DATA_WIDTH_2-1:0] s0_b_q, s0_b_d;
  logic [LAT-1:0]          vld_q, vld_d;
  logic [ID_W-1:0]         id_q [LAT];
  logic [ID_W-1:0]         id_d [LAT];

  logic [PW-1:0]           mul_p;
  logic [PW-1:0]           last_prod;
  logic                    last_vld;
  logic [ID_W-1:0]         last_id;

  // The whole pipeline freezes while the consumer refuses a presented result.
  assign stall = res_valid_o && !res_ready_i;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .en_i  (!stall && !rst),
    .gnt_o (gnt)
  );

  assign req_ready_o = gnt;
  assign gnt_any     = |gnt;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gnt_idx = ID_W'(i);
    end
  end

  always_comb begin
    ptr_d  = ptr_q;
    s0_a_d = s0_a_q;
    s0_b_d = s0_b_q;
    vld_d  = vld_q;
    id_d   = id_q;
    if (gnt_any) begin
      ptr_d  = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      s0_a_d = req_data1_i[int'(gnt_idx)*DATA_WIDTH_1 +: DATA_WIDTH_1];
      s0_b_d = req_data2_i[int'(gnt_idx)*DATA_WIDTH_2 +: DATA_WIDTH_2];
      id_d[0] = gnt_idx;
    end
    if (!stall) begin
      vld_d[0] = gnt_any;
      for (int i = 1; i < LAT; i++) begin
        vld_d[i] = vld_q[i-1];
        id_d[i]  = id_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      s0_a_q <= '0;
      s0_b_q <= '0;
      vld_q  <= '0;
      for (int i = 0; i < LAT; i++) id_q[i] <= '0;
    end else begin
      ptr_q  <= ptr_d;
      s0_a_q <= s0_a_d;
      s0_b_q <= s0_b_d;
      vld_q  <= vld_d;
      id_q   <= id_d;
    end
  end

  multiplier #(
    .DATA_WIDTH_1 (DATA_WIDTH_1),
    .DATA_WIDTH_2 (DATA_WIDTH_2)
  ) u_multiplier (
    .a_i (s0_a_q),
    .b_i (s0_b_q),
    .p_o (mul_p)
  );

  // Products only exist after stage 0, so the data delay line is one shorter than valid/id.
  if (LAT > 1) begin : g_prod_pipe
    logic [PW-1:0] prod_q [LAT-1];
    logic [PW-1:0] prod_d [LAT-1];

    always_comb begin
      prod_d = prod_q;
      if (!stall) begin
        prod_d[0] = mul_p;
        for (int i = 1; i < LAT - 1; i++) prod_d[i] = prod_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < LAT - 1; i++) prod_q[i] <= '0;
      end else begin
        prod_q <= prod_d;
      end
    end

    assign last_prod = prod_q[LAT-2];
  end else begin : g_prod_direct
    assign last_prod = mul_p;
  end

  assign last_vld = vld_q[LAT-1];
  assign last_id  = id_q[LAT-1];

`ifdef MULTIPLIER_ARB_REG_OUT_EN
  logic            out_vld_q, out_vld_d;
  logic [ID_W-1:0] out_id_q, out_id_d;
  logic [PW-1:0]   out_data_q, out_data_d;

  always_comb begin
    out_vld_d  = out_vld_q;
    out_id_d   = out_id_q;
    out_data_d = out_data_q;
    if (!stall) begin
      out_vld_d  = last_vld;
      out_id_d   = last_id;
      out_data_d = last_prod;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q  <= 1'b0;
      out_id_q   <= '0;
      out_data_q <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_id_q   <= out_id_d;
      out_data_q <= out_data_d;
    end
  end

  assign res_valid_o = out_vld_q;
  assign res_id_o    = out_id_q;
  assign res_data_o  = out_data_q;
`else
  assign res_valid_o = last_vld;
  assign res_id_o    = last_id;
  assign res_data_o  = last_prod;
`endif

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Self-checking bench for multiplier_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic against a queue-based reference model. Honours MULTIPLIER_ARB_REG_OUT_EN.
module tb_multiplier_arbiter;

  localparam int DW1     = 8;
  localparam int DW2     = 8;
  localparam int NUM_REQ = 4;
  localparam int LAT     = 2;
  localparam int ID_W    = 2;
  localparam int PW      = DW1 + DW2;
`ifdef MULTIPLIER_ARB_REG_OUT_EN
  localparam int TOT_LAT = LAT + 1;
`else
  localparam int TOT_LAT = LAT;
`endif

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid_i;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic [NUM_REQ*DW1-1:0]   req_data1_i;
  logic [NUM_REQ*DW2-1:0]   req_data2_i;
  logic                     res_valid_o;
  logic                     res_ready_i;
  logic [ID_W-1:0]          res_id_o;
  logic [PW-1:0]            res_data_o;

  multiplier_arbiter #(
    .DATA_WIDTH_1 (DW1),
    .DATA_WIDTH_2 (DW2),
    .NUM_REQ      (NUM_REQ),
    .LAT          (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_data1_i (req_data1_i),
    .req_data2_i (req_data2_i),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .res_id_o    (res_id_o),
    .res_data_o  (res_data_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: results in flight, each with the number of advancing edges since its grant.
  typedef struct {
    int          id;
    int unsigned p;
    int          age;
  } ent_t;
  ent_t mq[$];
  int   m_ptr = 0;

  typedef struct {
    logic [NUM_REQ-1:0] v;
    logic               rdy;
    logic [NUM_REQ-1:0] exp_g;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock cycle: drive, compare against the model, clock, advance the model.
  task automatic step(input logic [NUM_REQ-1:0] v, input logic [NUM_REQ*DW1-1:0] a,
                      input logic [NUM_REQ*DW2-1:0] b, input logic rdy, input logic rs,
                      output logic [NUM_REQ-1:0] g, output logic [NUM_REQ-1:0] dut_g);
    logic        m_vld, m_stall;
    int          gi;
    logic [31:0] sa, sb;
    req_valid_i = v;
    req_data1_i = a;
    req_data2_i = b;
    res_ready_i = rdy;
    rst         = rs;
    #1;
    m_vld   = (mq.size() > 0) && (mq[0].age == TOT_LAT);
    m_stall = m_vld && !rdy;
    g  = '0;
    gi = -1;
    if (!rs && !m_stall) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (gi < 0 && v[(m_ptr + k) % NUM_REQ]) gi = (m_ptr + k) % NUM_REQ;
      end
    end
    if (gi >= 0) g[gi] = 1'b1;
    dut_g = req_ready_o;
    chk("req_ready", 32'(req_ready_o), 32'(g));
    chk("res_valid", 32'(res_valid_o), 32'(m_vld));
    if (m_vld) begin
      chk("res_id", 32'(res_id_o), 32'(mq[0].id));
      chk("res_data", 32'(res_data_o), mq[0].p);
    end
    @(posedge clk);
    if (rs) begin
      mq.delete();
      m_ptr = 0;
    end else if (!m_stall) begin
      if (m_vld && rdy) void'(mq.pop_front());
      foreach (mq[j]) mq[j].age++;
      if (gi >= 0) begin
        sa = 32'(a[gi*DW1 +: DW1]);
        sb = 32'(b[gi*DW2 +: DW2]);
        mq.push_back('{gi, sa * sb, 1});
        m_ptr = (gi + 1) % NUM_REQ;
      end
    end
    @(negedge clk);
  endtask

  logic [NUM_REQ-1:0]     g, dg;
  logic [NUM_REQ*DW1-1:0] ta;
  logic [NUM_REQ*DW2-1:0] tb;
  logic [NUM_REQ-1:0]     hv;
  logic [NUM_REQ*DW1-1:0] ha;
  logic [NUM_REQ*DW2-1:0] hb;
  logic                   rr, rs;

  initial begin
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0010};
    tbl[6]  = '{4'b0100, 1'b1, 4'b0100};
    tbl[7]  = '{4'b1100, 1'b1, 4'b1000};
    tbl[8]  = '{4'b1100, 1'b1, 4'b0100};
    tbl[9]  = '{4'b1010, 1'b1, 4'b1000};
    tbl[10] = '{4'b0000, 1'b1, 4'b0000};
    tbl[11] = '{4'b0011, 1'b1, 4'b0001};
    tbl[12] = '{4'b0000, 1'b1, 4'b0000};
    tbl[13] = '{4'b0000, 1'b1, 4'b0000};
    tbl[14] = '{4'b0000, 1'b1, 4'b0000};
    ta = {8'd9, 8'd17, 8'd0, 8'd255};
    tb = {8'd13, 8'd3, 8'd200, 8'd255};

    rst = 1'b1;
    req_valid_i = '0;
    req_data1_i = '0;
    req_data2_i = '0;
    res_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    req_valid_i = '1;
    #1;
    chk("reset_ready", 32'(req_ready_o), 32'd0);
    chk("reset_valid", 32'(res_valid_o), 32'd0);
    chk("reset_id", 32'(res_id_o), 32'd0);
    chk("reset_data", 32'(res_data_o), 32'd0);
    step('0, '0, '0, 1'b1, 1'b1, g, dg);

    // Single request: requester 1 offers 34 x 22.
    step(4'b0010, 32'(34) << 8, 32'(22) << 8, 1'b1, 1'b0, g, dg);
    chk("single_ready", 32'(dg), 32'b0010);
    repeat (TOT_LAT - 1) step('0, '0, '0, 1'b1, 1'b0, g, dg);
    chk("single_valid", 32'(res_valid_o), 32'd1);
    chk("single_id", 32'(res_id_o), 32'd1);
    chk("single_data", 32'(res_data_o), 32'd748);
    step('0, '0, '0, 1'b1, 1'b0, g, dg);

    // Vector table from a fresh reset.
    step('0, '0, '0, 1'b1, 1'b1, g, dg);
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].v, ta, tb, tbl[i].rdy, 1'b0, g, dg);
      chk($sformatf("tbl_ready[%0d]", i), 32'(dg), 32'(tbl[i].exp_g));
    end

    // Extreme operands: 255 x 255 then 0 x 200.
    step('0, '0, '0, 1'b1, 1'b1, g, dg);
    step(4'b0001, ta, tb, 1'b1, 1'b0, g, dg);
    step(4'b0010, ta, tb, 1'b1, 1'b0, g, dg);
    repeat (TOT_LAT - 2) step('0, '0, '0, 1'b1, 1'b0, g, dg);
    chk("max_id", 32'(res_id_o), 32'd0);
    chk("max_data", 32'(res_data_o), 32'd65025);
    step('0, '0, '0, 1'b1, 1'b0, g, dg);
    chk("zero_valid", 32'(res_valid_o), 32'd1);
    chk("zero_id", 32'(res_id_o), 32'd1);
    chk("zero_data", 32'(res_data_o), 32'd0);
    step('0, '0, '0, 1'b1, 1'b0, g, dg);

    // Three-cycle stall with two results in flight.
    step('0, '0, '0, 1'b1, 1'b1, g, dg);
    step(4'b0001, {8'd0, 8'd0, 8'd7, 8'd12}, {8'd0, 8'd0, 8'd9, 8'd10}, 1'b1, 1'b0, g, dg);
    step(4'b0010, {8'd0, 8'd0, 8'd7, 8'd12}, {8'd0, 8'd0, 8'd9, 8'd10}, 1'b1, 1'b0, g, dg);
    repeat (TOT_LAT - 2) step('0, '0, '0, 1'b1, 1'b0, g, dg);
    for (int i = 0; i < 3; i++) begin
      step(4'b1111, ta, tb, 1'b0, 1'b0, g, dg);
      chk($sformatf("stall_ready[%0d]", i), 32'(dg), 32'd0);
      chk($sformatf("stall_valid[%0d]", i), 32'(res_valid_o), 32'd1);
      chk($sformatf("stall_id[%0d]", i), 32'(res_id_o), 32'd0);
      chk($sformatf("stall_data[%0d]", i), 32'(res_data_o), 32'd120);
    end
    step('0, '0, '0, 1'b1, 1'b0, g, dg);
    chk("unstall_id", 32'(res_id_o), 32'd1);
    chk("unstall_data", 32'(res_data_o), 32'd63);
    step('0, '0, '0, 1'b1, 1'b0, g, dg);
    chk("unstall_drained", 32'(res_valid_o), 32'd0);

    // Reset with two results in flight, then the search restarts at requester 0.
    step('0, '0, '0, 1'b1, 1'b1, g, dg);
    step(4'b0001, ta, tb, 1'b1, 1'b0, g, dg);
    step(4'b0010, ta, tb, 1'b1, 1'b0, g, dg);
    step(4'b1111, ta, tb, 1'b1, 1'b1, g, dg);
    chk("midrst_valid", 32'(res_valid_o), 32'd0);
    chk("midrst_id", 32'(res_id_o), 32'd0);
    chk("midrst_data", 32'(res_data_o), 32'd0);
    step(4'b1111, ta, tb, 1'b1, 1'b0, g, dg);
    chk("midrst_first_grant", 32'(dg), 32'b0001);
    repeat (TOT_LAT + 1) step('0, '0, '0, 1'b1, 1'b0, g, dg);

    // Randomized traffic; requesters hold valid and data until granted, or occasionally give up.
    hv = '0;
    ha = '0;
    hb = '0;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!hv[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            hv[i] = 1'b1;
            ha[i*DW1 +: DW1] = DW1'($urandom_range(0, 255));
            hb[i*DW2 +: DW2] = DW2'($urandom_range(0, 255));
          end
        end else if ($urandom_range(0, 15) == 0) begin
          hv[i] = 1'b0;
        end
      end
      rr = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 199) == 0);
      step(hv, ha, hb, rr, rs, g, dg);
      hv = hv & ~g;
    end
    repeat (TOT_LAT + 2) step('0, '0, '0, 1'b1, 1'b0, g, dg);
    chk("final_empty", 32'(res_valid_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multiplier_arbiter.md
# multiplier_arbiter

Shares one unsigned `multiplier` datapath among NUM_REQ independent requesters. Each requester offers an operand pair with a valid/ready handshake. A round-robin arbiter grants at most one pair per cycle into a fixed-latency pipeline around the multiplier. Results come out in grant order, tagged with the requester index, under a single valid/ready handshake that can stall the whole pipeline.

## Interface
Parameters:
- DATA_WIDTH_1, 8: width of operand 1.
- DATA_WIDTH_2, 8: width of operand 2.
- NUM_REQ, 4: number of requesters; legal range 2..8.
- LAT, 2: register stages from grant to result; must be 1 or more.

Ports (one clock; reset is synchronous and active-high; clock `clk`, reset `rst`):
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid_i  in  NUM_REQ  per-requester operand valid.
- req_ready_o  out  NUM_REQ  per-requester grant; one-hot or zero.
- req_data1_i  in  NUM_REQ*DATA_WIDTH_1  packed operand 1; requester i occupies slice [i*DATA_WIDTH_1 +: DATA_WIDTH_1].
- req_data2_i  in  NUM_REQ*DATA_WIDTH_2  packed operand 2, same slicing.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  consumer accepts the result.
- res_id_o  out  ID_W  index of the requester that owns the result; ID_W = clog2(NUM_REQ).
- res_data_o  out  DATA_WIDTH_1+DATA_WIDTH_2  product.

## Operation
- Transfers:
  - A request transfer occurs on an edge where req_valid_i[i] && req_ready_o[i].
  - A result transfer occurs on an edge where res_valid_o && res_ready_i.
- Stall: stall = res_valid_o && !res_ready_i. While stall is high, every pipeline register holds and req_ready_o is all zero.
- Arbitration:
  - A round-robin pointer `ptr` (ID_W bits) selects the search start.
  - Grant goes to the first i with req_valid_i[i] high, searching ptr, ptr+1, … with wrap modulo NUM_REQ.
  - req_ready_o is combinational from req_valid_i, ptr and stall. Ready may depend on valid.
  - After a grant to i, ptr becomes (i+1) mod NUM_REQ. With no grant, ptr holds.
- Pipeline:
  - The stage-0 register captures operands, id and valid on a grant. Stage-0 valid is cleared when there is no grant and no stall.
  - The product is formed by the shared multiplier from the stage-0 operands, then delayed through LAT-1 further register stages with id and valid.
  - Results never reorder.
- Arithmetic: unsigned, full-width product, no truncation or saturation.
- Requester side: a requester must hold its valid and data until it sees ready. Dropping valid without ready is legal and simply loses arbitration.
- Reset values: ptr = 0, all stage valids = 0, res_valid_o = 0, res_id_o = 0, res_data_o = 0, req_ready_o = 0 while rst is high.
- Reset mid-operation: in-flight products are discarded without being presented. The first grant after reset searches from requester 0.

## Timing
- Latency: a grant on edge k makes res_valid_o high after edge k+LAT (k+LAT+1 when the output register is enabled), provided no stall occurs in between.
- Throughput: one grant and one result per cycle when res_ready_i is held high.
- Stall: a stall of S cycles delays every in-flight result by exactly S cycles.
- Simultaneous grant and stall: impossible, since stall forces ready low.
- Pipeline full with res_ready_i low: no loss of data and no duplication.

## Configuration
- MULTIPLIER_ARB_REG_OUT_EN defined:
  - An extra register follows the last stage and drives res_* outputs.
  - Latency becomes LAT+1.
  - The stall rule applies unchanged.
- Undefined: res_* are driven directly from the last pipeline stage registers; latency is LAT.

## Structure
- Shared package `multiplier_pkg`:
  - clog2 function.
  - ID_W derivation.
  - Legal NUM_REQ bounds.
- The round-robin grant logic is its own sub-module, `rr_arbiter`, with inputs req, ptr and enable and a one-hot grant output. It is reusable elsewhere.
- The existing `multiplier` is instantiated once as the datapath.

## Test plan
NUM_REQ=4, LAT=2, 8-bit operands.
- Single request: requester 1 offers 34×22 → ready[1] high the same cycle; after two edges res_valid_o=1, res_id_o=1, res_data_o=748.
- All four requesters valid continuously from reset → grants 0,1,2,3,0,1 on consecutive cycles; results 1 per cycle with ids in the same order.
- Requesters 2 and 3 valid with ptr=3 → grant 3 first, then 2; a requester dropping valid before grant produces no result.
- res_ready_i low for 3 cycles with 2 results in flight → res outputs held stable, req_ready_o=0; after release both delivered in order, none lost.
- Operands 255×255 → res_data_o=65025; 0×200 → 0.
- rst asserted for 1 cycle with 2 results in flight → res_valid_o=0 after that edge; next grant searches from requester 0; with MULTIPLIER_ARB_REG_OUT_EN defined, single-request latency is 3 edges.
